// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin grant/hold/timeout/release sequencer for requesters 1..15
module rr_grant_scheduler #(
   parameter int MAX_HOLD   = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [14:0] req,
   output logic [3:0]  grant_idx,
   output logic [14:0] grant_vec,
   output logic        busy,
   output logic        timeout,
   output logic [3:0]  last_idx
);
   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
   state_t state, state_n;
   logic [7:0] hold_cnt, hold_n;
   logic [1:0] gap_cnt, gap_n;
   logic [3:0] idx_n, last_n, win;
   logic to_n, own_req, cap, arb;

   function automatic logic [3:0] pick(input logic [14:0] r, input logic [3:0] p);
      logic [4:0] s;
      pick = 4'd0;
      for (int i = 15; i >= 1; i--) begin
         s = {1'b0, p} + 5'(i);
         s = (s > 5'd15) ? s - 5'd15 : s;
         if (r[s[3:0] - 4'd1]) pick = s[3:0];
      end
   endfunction

   assign win     = pick(req, last_idx);
   assign own_req = (grant_idx == 4'd0) ? 1'b0 : req[grant_idx - 4'd1];
   assign cap     = (MAX_HOLD != 0) && (hold_cnt == 8'(MAX_HOLD));
   assign arb     = en && |req;

   always_comb begin
      state_n = state;
      idx_n   = grant_idx;
      hold_n  = hold_cnt;
      gap_n   = gap_cnt;
      last_n  = last_idx;
      to_n    = 1'b0;
      if (state == GRANT) begin
         if (!own_req || cap) begin
            state_n = GAP;
            idx_n   = 4'd0;
            last_n  = grant_idx;
            gap_n   = 2'd1;
            to_n    = own_req;
         end else begin
            hold_n = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
         end
      end else if (state == IDLE || gap_cnt == 2'(GAP_CYCLES)) begin
         state_n = arb ? GRANT : IDLE;
         idx_n   = arb ? win : 4'd0;
         hold_n  = arb ? 8'd1 : hold_cnt;
         gap_n   = 2'd0;
      end else begin
         gap_n = gap_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant_idx <= 4'd0;
         grant_vec <= '0;
         busy      <= 1'b0;
         timeout   <= 1'b0;
         last_idx  <= 4'd15;
         hold_cnt  <= 8'd0;
         gap_cnt   <= 2'd0;
      end else begin
         state     <= state_n;
         grant_idx <= idx_n;
         grant_vec <= (idx_n == 4'd0) ? '0 : 15'd1 << (idx_n - 4'd1);
         busy      <= idx_n != 4'd0;
         timeout   <= to_n;
         last_idx  <= last_n;
         hold_cnt  <= hold_n;
         gap_cnt   <= gap_n;
      end
   end
endmodule
